// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer around one external full adder.
// The operands are presented to the full adder LSB first, one bit per clock.
// The carry is held in a flip-flop between bits, and the sum is assembled in a
// shift register. An add takes WIDTH+1 cycles from start to result.
// Optional feature macro: SERIAL_ADD_SUB_EN. When defined, the block has an iSub
// input that selects subtraction (iA - iB, where oCout=1 means no borrow).
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iCin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             iSub,
`endif
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oSum,
  output logic             oCout,
  output logic             oFaA,
  output logic             oFaB,
  output logic             oFaC,
  input  logic             iFaS,
  input  logic             iFaC
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sumsr;

  logic [WIDTH-1:0] b_cap;
  logic             c_cap;
  logic [WIDTH:0]   sum_shift;
  logic             unused_lsb;
  logic             run;

  // Operand B / carry-in as loaded at accept (inverted B plus one when subtracting)
  always_comb begin
    b_cap = iB;
    c_cap = iCin;
`ifdef SERIAL_ADD_SUB_EN
    if (iSub) begin
      b_cap = ~iB;
      c_cap = 1'b1;
    end
`endif
  end

  // New sum bit enters at the MSB; the old LSB falls off the end each bit
  assign sum_shift  = {iFaS, sumsr};
  assign unused_lsb = sum_shift[0];

  // Full adder is only driven while bits are being processed
  assign run  = (state == S_RUN);
  assign oFaA = run & op_a[0];
  assign oFaB = run & op_b[0];
  assign oFaC = run & carry;

  // Sequencer: accept, shift one bit per cycle, publish result on the last bit
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state <= S_IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
      sumsr <= '0;
      oSum  <= '0;
      oCout <= 1'b0;
      oBusy <= 1'b0;
      oDone <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          oDone <= 1'b0;
          if (iStart) begin
            op_a  <= iA;
            op_b  <= b_cap;
            carry <= c_cap;
            cnt   <= '0;
            sumsr <= '0;
            oBusy <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          sumsr <= sum_shift[WIDTH:1];
          carry <= iFaC;
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            oSum  <= sum_shift[WIDTH:1];
            oCout <= iFaC;
            oDone <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          oDone <= 1'b0;
          oBusy <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          oDone <= 1'b0;
          oBusy <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl (WIDTH=8) with a behavioural full adder on the FA port.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         fa_a;
  logic         fa_b;
  logic         fa_c;
  logic         fa_s;
  logic         fa_co;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign fa_s  = fa_a ^ fa_b ^ fa_c;
  assign fa_co = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

  serial_add_ctrl #(.WIDTH(W)) dut (
    .iClk   (clk),
    .iRst   (rst),
    .iStart (start),
    .iA     (a),
    .iB     (b),
    .iCin   (cin),
`ifdef SERIAL_ADD_SUB_EN
    .iSub   (sub),
`endif
    .oBusy  (busy),
    .oDone  (done),
    .oSum   (sum),
    .oCout  (cout),
    .oFaA   (fa_a),
    .oFaB   (fa_b),
    .oFaC   (fa_c),
    .iFaS   (fa_s),
    .iFaC   (fa_co)
  );

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic s);
    logic [W-1:0] ny;
    ny = ~y;
    if (s) return (W+1)'(x) + (W+1)'(ny) + (W+1)'(1);
    return (W+1)'(x) + (W+1)'(y) + (W+1)'(c);
  endfunction

  // Drives one add from IDLE, scrambles operand inputs after acceptance, waits for oDone.
  // lat counts rising edges from the accept edge up to and including the one raising oDone.
  task automatic run_add(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                         input logic xs, output logic [W-1:0] s, output logic co,
                         output int lat);
    @(negedge clk);
    a = xa; b = xb; cin = xc; sub = xs; start = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    end
    if (done !== 1'b1) lat = -1;
    s = sum;
    co = cout;
    sub = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    total++;
    if ({busy, done, sum, cout, fa_a, fa_b, fa_c} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b fa=%b%b%b want all 0",
               busy, done, sum, cout, fa_a, fa_b, fa_c);
    end
    start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_holds: busy=%b want 0", busy);
    end
    start = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [W-1:0] s;
    logic co;
    int lat;
    logic [W:0] exp;
    logic [W-1:0] va [3] = '{8'h0F, 8'hFF, 8'hFF};
    logic [W-1:0] vb [3] = '{8'h01, 8'h01, 8'hFF};
    logic         vc [3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      exp = ref_add(va[i], vb[i], vc[i], 1'b0);
      run_add(va[i], vb[i], vc[i], 1'b0, s, co, lat);
      total++;
      if ({co, s} !== exp || lat != W + 1) begin
        bad++;
        $display("FAIL directed_%0d: got cout=%b sum=%h lat=%0d want cout=%b sum=%h lat=%0d",
                 i, co, s, lat, exp[W], exp[W-1:0], W + 1);
      end
    end
    repeat (3) @(negedge clk);
    total++;
    if ({cout, sum} !== exp || done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL result_held: got cout=%b sum=%h done=%b busy=%b want cout=%b sum=%h done=0 busy=0",
               cout, sum, done, busy, exp[W], exp[W-1:0]);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] s, xa, xb;
    logic co, xc;
    int lat;
    logic [W:0] exp;
    for (int i = 0; i < 30; i++) begin
      xa = W'($urandom); xb = W'($urandom); xc = 1'($urandom);
      exp = ref_add(xa, xb, xc, 1'b0);
      run_add(xa, xb, xc, 1'b0, s, co, lat);
      total++;
      if ({co, s} !== exp || lat != W + 1) begin
        bad++;
        $display("FAIL random_%0d: %h+%h+%b got cout=%b sum=%h lat=%0d want cout=%b sum=%h lat=%0d",
                 i, xa, xb, xc, co, s, lat, exp[W], exp[W-1:0], W + 1);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] a1, b1, a2, b2;
    logic c1, c2;
    logic [W:0] e1, e2, got;
    int pulses;
    int first_k;
    int second_k;
    a1 = W'($urandom); b1 = W'($urandom); c1 = 1'($urandom);
    a2 = W'($urandom); b2 = W'($urandom); c2 = 1'($urandom);
    e1 = ref_add(a1, b1, c1, 1'b0);
    e2 = ref_add(a2, b2, c2, 1'b0);
    pulses = 0; first_k = -1; second_k = -1;
    @(negedge clk);
    a = a1; b = b1; cin = c1; start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 5) begin
        a = a2; b = b2; cin = c2;
      end
      total++;
      if (busy !== ((k % (W + 2)) != 0)) begin
        bad++;
        $display("FAIL b2b_busy_k%0d: busy=%b want %b", k, busy, (k % (W + 2)) != 0);
      end
      if (done === 1'b1) begin
        pulses++;
        got = {cout, sum};
        if (pulses == 1) first_k = k;
        if (pulses == 2) second_k = k;
        total++;
        if (got !== ((pulses == 1) ? e1 : e2)) begin
          bad++;
          $display("FAIL b2b_result_%0d: got %h want %h", pulses, got, (pulses == 1) ? e1 : e2);
        end
      end
    end
    start = 1'b0;
    total++;
    if (pulses != 2 || first_k != W + 1 || second_k - first_k != W + 2) begin
      bad++;
      $display("FAIL b2b_pulses: got n=%0d at %0d,%0d want n=2 at %0d,%0d",
               pulses, first_k, second_k, W + 1, 2 * W + 3);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abort;
    logic [W-1:0] s;
    logic co;
    int lat;
    int stray;
    logic [W:0] exp;
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || fa_a !== 1'b1 || fa_b !== 1'b1 || fa_c !== 1'b1) begin
      bad++;
      $display("FAIL abort_pre: busy=%b fa=%b%b%b want 1 111", busy, fa_a, fa_b, fa_c);
    end
    rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || sum !== '0 || cout !== 1'b0 || {fa_a, fa_b, fa_c} !== 3'b000) begin
      bad++;
      $display("FAIL abort_reset: busy=%b sum=%h cout=%b fa=%b%b%b want 0 00 0 000",
               busy, sum, cout, fa_a, fa_b, fa_c);
    end
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    repeat (15) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) stray++;
    end
    total++;
    if (stray != 0) begin
      bad++;
      $display("FAIL abort_no_done: %0d cycles with done/busy set, want 0", stray);
    end
    exp = ref_add(8'h3C, 8'hA7, 1'b1, 1'b0);
    run_add(8'h3C, 8'hA7, 1'b1, 1'b0, s, co, lat);
    total++;
    if ({co, s} !== exp || lat != W + 1) begin
      bad++;
      $display("FAIL abort_recover: got %b_%h lat=%0d want %b_%h lat=%0d",
               co, s, lat, exp[W], exp[W-1:0], W + 1);
    end
  endtask

  task automatic test_operand_change;
    logic [W-1:0] s;
    logic co;
    int lat;
    logic [W:0] exp;
    exp = ref_add(8'h55, 8'hAA, 1'b0, 1'b0);
    run_add(8'h55, 8'hAA, 1'b0, 1'b0, s, co, lat);
    total++;
    if ({co, s} !== exp) begin
      bad++;
      $display("FAIL opchange_0: got %b_%h want %b_%h", co, s, exp[W], exp[W-1:0]);
    end
    exp = ref_add(8'h80, 8'h80, 1'b1, 1'b0);
    run_add(8'h80, 8'h80, 1'b1, 1'b0, s, co, lat);
    total++;
    if ({co, s} !== exp) begin
      bad++;
      $display("FAIL opchange_1: got %b_%h want %b_%h", co, s, exp[W], exp[W-1:0]);
    end
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub;
    logic [W-1:0] s, xa, xb;
    logic co;
    int lat;
    logic [W:0] exp;
    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin xa = 8'd5; xb = 8'd7; end
      else if (i == 1) begin xa = 8'd7; xb = 8'd5; end
      else begin xa = W'($urandom); xb = W'($urandom); end
      exp = ref_add(xa, xb, 1'($urandom), 1'b1);
      run_add(xa, xb, 1'b0, 1'b1, s, co, lat);
      total++;
      if ({co, s} !== exp) begin
        bad++;
        $display("FAIL sub_%0d: %h-%h got cout=%b sum=%h want cout=%b sum=%h",
                 i, xa, xb, co, s, exp[W], exp[W-1:0]);
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_abort();
    test_operand_change();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
